// File: rtl/seq_job_launcher_if.sv
// Host/sequencer signal bundle for seq_job_launcher.
//
// Groups the host command channel (cmd_*), the response channel (rsp_*),
// the sequencer handshake (run, n_func, busy) and the idle status flag.
//   master : the launcher's view (drives cmd_ready, run, n_func, rsp_*, idle)
//   slave  : the environment's view (host plus sequencer)
interface seq_job_launcher_if #(
    parameter int unsigned CNT_W = 20
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_func;
    logic [3:0]       cmd_tag;
    logic             run;
    logic [3:0]       n_func;
    logic             busy;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [3:0]       rsp_tag;
    logic [1:0]       rsp_status;
    logic [CNT_W-1:0] rsp_cycles;
    logic             idle;

    modport master (
        input  cmd_valid, cmd_func, cmd_tag, busy, rsp_ready,
        output cmd_ready, run, n_func, rsp_valid, rsp_tag, rsp_status, rsp_cycles, idle
    );

    modport slave (
        output cmd_valid, cmd_func, cmd_tag, busy, rsp_ready,
        input  cmd_ready, run, n_func, rsp_valid, rsp_tag, rsp_status, rsp_cycles, idle
    );
endinterface

// File: rtl/seq_job_launcher.sv
// Host-side job launcher for the microcode sequencer run/n_func/busy handshake.
//
// Host commands are queued, then launched one at a time: a single-cycle run
// pulse with n_func held, busy rise/fall supervised with a start timeout and a
// run timeout, and one tagged response returned per job.
//
// Ports:
//   clk  : clock
//   rstn : asynchronous active-low reset
//   bus  : seq_job_launcher_if.master
//          cmd_valid/cmd_ready/cmd_func/cmd_tag      host command (queue push)
//          run/n_func/busy                           sequencer handshake
//          rsp_valid/rsp_ready/rsp_tag/rsp_status/rsp_cycles  job response
//          idle                                      FSM idle and queue empty
//
// rsp_status: 00 ok, 01 start timeout, 10 run timeout.
module seq_job_launcher #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned START_TO   = 8,
    parameter int unsigned CNT_W      = 20
) (
    input  logic clk,
    input  logic rstn,
    seq_job_launcher_if.master bus
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned WAIT_W = $clog2(START_TO + 1);

    localparam logic [PTR_W:0]    CountFull = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]    CountOne  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0]  PtrOne    = PTR_W'(1);
    localparam logic [WAIT_W-1:0] WaitLast  = WAIT_W'(START_TO - 1);
    localparam logic [WAIT_W-1:0] WaitOne   = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CycMax    = '1;
    localparam logic [CNT_W-1:0]  CycOne    = CNT_W'(1);

    localparam logic [1:0] StatusOk       = 2'b00;
    localparam logic [1:0] StatusStartTo  = 2'b01;
    localparam logic [1:0] StatusRunTo    = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitStart,
        StRunning,
        StRespond,
        StDrain
    } state_t;

    state_t state_q, state_d;

    // Command queue
    logic [3:0]       fifo_func_q [FIFO_DEPTH];
    logic [3:0]       fifo_tag_q  [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             cmd_ready_q;
    logic             push, pop;

    // Job / response state
    logic [3:0]        n_func_q, n_func_d;
    logic [3:0]        tag_q, tag_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic [1:0]        status_q, status_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_hs;

    assign push   = bus.cmd_valid && cmd_ready_q;
    // A busy sequencer seen while idle (stale run or glitch) blocks launching.
    assign pop    = (state_q == StIdle) && (count_q != '0) && !bus.busy;
    assign rsp_hs = rsp_valid_q && bus.rsp_ready;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CountOne;
        end else if (pop && !push) begin
            count_d = count_q - CountOne;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_func_q[wr_ptr_q] <= bus.cmd_func;
            fifo_tag_q[wr_ptr_q]  <= bus.cmd_tag;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            count_q     <= count_d;
            // Registered so cmd_ready never depends combinationally on cmd_valid.
            cmd_ready_q <= (count_d != CountFull);
        end
    end

    always_comb begin
        state_d     = state_q;
        n_func_d    = n_func_q;
        tag_d       = tag_q;
        wait_d      = wait_q;
        cycles_d    = cycles_q;
        status_d    = status_q;
        rsp_valid_d = rsp_valid_q;

        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    n_func_d = fifo_func_q[rd_ptr_q];
                    tag_d    = fifo_tag_q[rd_ptr_q];
                    state_d  = StLaunch;
                end
            end
            StLaunch: begin
                wait_d   = '0;
                cycles_d = '0;
                status_d = StatusOk;
                state_d  = StWaitStart;
            end
            StWaitStart: begin
                if (bus.busy) begin
                    // The rising cycle itself is the first busy cycle.
                    cycles_d = CycOne;
                    state_d  = StRunning;
                end else if (wait_q == WaitLast) begin
                    status_d    = StatusStartTo;
                    cycles_d    = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = StRespond;
                end else begin
                    wait_d = wait_q + WaitOne;
                end
            end
            StRunning: begin
                if (!bus.busy) begin
                    status_d    = StatusOk;
                    rsp_valid_d = 1'b1;
                    state_d     = StRespond;
                end else if (cycles_q == CycMax) begin
                    // Counter saturated with busy still high: report, then wait it out.
                    status_d    = StatusRunTo;
                    rsp_valid_d = 1'b1;
                    state_d     = StDrain;
                end else begin
                    cycles_d = cycles_q + CycOne;
                end
            end
            StRespond: begin
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            StDrain: begin
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                end
                if ((rsp_hs || !rsp_valid_q) && !bus.busy) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            n_func_q    <= '0;
            tag_q       <= '0;
            wait_q      <= '0;
            cycles_q    <= '0;
            status_q    <= StatusOk;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_func_q    <= n_func_d;
            tag_q       <= tag_d;
            wait_q      <= wait_d;
            cycles_q    <= cycles_d;
            status_q    <= status_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // run decodes straight from the state register so reset clears it at once.
    assign bus.run        = (state_q == StLaunch);
    assign bus.n_func     = n_func_q;
    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_tag    = tag_q;
    assign bus.rsp_status = status_q;
    assign bus.rsp_cycles = cycles_q;
    assign bus.idle       = (state_q == StIdle) && (count_q == '0);

endmodule

// File: tb/tb_seq_job_launcher.sv
// Self-checking bench for seq_job_launcher (FIFO_DEPTH=4, START_TO=8, CNT_W=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seq_job_launcher;

    localparam int unsigned CW = 4;

    logic clk;
    logic rstn;

    seq_job_launcher_if #(.CNT_W(CW)) bus ();

    seq_job_launcher #(
        .FIFO_DEPTH (4),
        .START_TO   (8),
        .CNT_W      (CW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] func;
        logic [3:0] tag;
        int         dly;    // cycles after run before busy rises
        int         len;    // busy-high cycles (0: never rises)
        int         hold;   // cycles rsp_ready held low once rsp_valid is seen
        bit         early;  // rsp_ready already high before rsp_valid
        logic [1:0] st;
        int         cyc;
    } vec_t;

    int   n_err;
    int   n_chk;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] f, input logic [3:0] t, input int d,
                                input int l, input int h, input bit e, input logic [1:0] s,
                                input int c);
        vec_t v;
        v.func = f; v.tag = t; v.dly = d; v.len = l; v.hold = h; v.early = e;
        v.st = s; v.cyc = c;
        return v;
    endfunction

    task automatic chk_reset_outputs();
        chk("rst_run",        32'(bus.run),        0);
        chk("rst_n_func",     32'(bus.n_func),     0);
        chk("rst_rsp_valid",  32'(bus.rsp_valid),  0);
        chk("rst_rsp_tag",    32'(bus.rsp_tag),    0);
        chk("rst_rsp_status", 32'(bus.rsp_status), 0);
        chk("rst_rsp_cycles", 32'(bus.rsp_cycles), 0);
        chk("rst_cmd_ready",  32'(bus.cmd_ready),  1);
        chk("rst_idle",       32'(bus.idle),       1);
    endtask

    task automatic push(input logic [3:0] func, input logic [3:0] tag);
        chk("push_ready", 32'(bus.cmd_ready), 1);
        bus.cmd_func  = func;
        bus.cmd_tag   = tag;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_run(input logic [3:0] func, input int exp_lat);
        int lat = 0;
        while (bus.run !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("run_pulse", 32'(bus.run), 1);
        chk("n_func", 32'(bus.n_func), 32'(func));
        if (exp_lat >= 0) chk("launch_latency", lat, exp_lat);
    endtask

    task automatic wait_rsp(input logic [3:0] tag, input logic [1:0] st, input int cyc);
        int n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_valid",  32'(bus.rsp_valid),  1);
        chk("rsp_tag",    32'(bus.rsp_tag),    32'(tag));
        chk("rsp_status", 32'(bus.rsp_status), 32'(st));
        chk("rsp_cycles", 32'(bus.rsp_cycles), cyc);
    endtask

    task automatic handshake();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_cleared", 32'(bus.rsp_valid), 0);
    endtask

    task automatic serve(input vec_t v, input int exp_lat);
        bit stable;
        bit ran;
        if (v.early) bus.rsp_ready = 1'b1;
        wait_run(v.func, exp_lat);
        @(negedge clk);
        chk("run_one_cycle", 32'(bus.run), 0);
        repeat (v.dly) @(negedge clk);
        if (v.len > 0) begin
            bus.busy = 1'b1;
            repeat (v.len) @(negedge clk);
            bus.busy = 1'b0;
        end
        wait_rsp(v.tag, v.st, v.cyc);
        chk("n_func_held", 32'(bus.n_func), 32'(v.func));
        if (v.early) begin
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            chk("rsp_cleared_early", 32'(bus.rsp_valid), 0);
        end else begin
            if (v.hold > 0) begin
                stable = 1'b1;
                ran    = 1'b0;
                repeat (v.hold) begin
                    @(negedge clk);
                    if (bus.run === 1'b1) ran = 1'b1;
                    if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== v.tag ||
                        bus.rsp_status !== v.st || 32'(bus.rsp_cycles) !== v.cyc)
                        stable = 1'b0;
                end
                chk("hold_stable", 32'(stable), 1);
                chk("hold_no_run", 32'(ran), 0);
            end
            handshake();
        end
    endtask

    task automatic watch_no_run(input string name, input int n);
        bit ran = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (bus.run === 1'b1) ran = 1'b1;
        end
        chk(name, 32'(ran), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_err = 0;
        n_chk = 0;

        // func, tag, dly, len, hold, early, status, cycles
        vecs[0] = mk(4'h1, 4'h3, 0, 10, 0, 1'b0, 2'b00, 10);
        vecs[1] = mk(4'h2, 4'h9, 3,  1, 3, 1'b0, 2'b00,  1);
        vecs[2] = mk(4'hF, 4'hA, 7,  4, 0, 1'b0, 2'b00,  4);  // rises on last allowed cycle
        vecs[3] = mk(4'h4, 4'h1, 8,  2, 0, 1'b0, 2'b01,  0);  // rises one cycle too late
        vecs[4] = mk(4'hC, 4'hF, 0, 15, 0, 1'b0, 2'b00, 15);  // longest non-timeout run
        vecs[5] = mk(4'h7, 4'h2, 1,  5, 0, 1'b1, 2'b00,  5);

        rstn          = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_func  = '0;
        bus.cmd_tag   = '0;
        bus.busy      = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rstn = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", 32'(bus.idle), 1);

        // Single jobs from idle: push, launch two cycles later, respond.
        for (int i = 0; i < 6; i++) begin
            push(vecs[i].func, vecs[i].tag);
            serve(vecs[i], 1);
        end

        // Back-to-back; busy held high meanwhile so nothing launches from idle.
        bus.busy = 1'b1;
        push(4'h0, 4'h5);
        push(4'h2, 4'h6);
        push(4'h1, 4'h7);
        watch_no_run("busy_in_idle_no_run", 4);
        chk("busy_in_idle_not_idle", 32'(bus.idle), 0);
        bus.busy = 1'b0;
        serve(mk(4'h0, 4'h5, 0, 3, 0, 1'b0, 2'b00, 3), 1);
        serve(mk(4'h2, 4'h6, 1, 2, 0, 1'b0, 2'b00, 2), 1);
        serve(mk(4'h1, 4'h7, 0, 6, 0, 1'b0, 2'b00, 6), 1);

        // Start timeout, then the queued job still launches.
        push(4'h4, 4'hC);
        push(4'h8, 4'hD);
        serve(mk(4'h4, 4'hC, 0, 0, 0, 1'b0, 2'b01, 0), 0);
        serve(mk(4'h8, 4'hD, 0, 3, 0, 1'b0, 2'b00, 3), 1);

        // Queue full: one job running plus four queued.
        push(4'h1, 4'h0);
        wait_run(4'h1, 1);
        @(negedge clk);
        bus.busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("qfull_ready", 32'(bus.cmd_ready), 1);
            bus.cmd_func  = 4'(i);
            bus.cmd_tag   = 4'(i);
            bus.cmd_valid = 1'b1;
            @(negedge clk);
        end
        bus.cmd_func = 4'h5;
        bus.cmd_tag  = 4'h5;
        chk("qfull_not_ready", 32'(bus.cmd_ready), 0);
        @(negedge clk);
        chk("qfull_still_not_ready", 32'(bus.cmd_ready), 0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.busy      = 1'b0;
        wait_rsp(4'h0, 2'b00, 6);
        handshake();
        begin
            int n = 0;
            while (bus.cmd_ready !== 1'b1 && n < 5) begin
                @(negedge clk);
                n++;
            end
        end
        chk("qfull_ready_again", 32'(bus.cmd_ready), 1);
        serve(mk(4'h1, 4'h1, 0, 2, 0, 1'b0, 2'b00, 2), 0);
        for (int i = 2; i <= 4; i++) begin
            serve(mk(4'(i), 4'(i), 0, 2, 0, 1'b0, 2'b00, 2), 1);
        end
        watch_no_run("qfull_dropped_push", 10);
        chk("qfull_idle_after", 32'(bus.idle), 1);

        // Run timeout (CNT_W=4): busy stuck high, no launch until it falls.
        push(4'h5, 4'h2);
        push(4'h6, 4'h4);
        wait_run(4'h5, 0);
        @(negedge clk);
        bus.busy = 1'b1;
        wait_rsp(4'h2, 2'b10, 15);
        handshake();
        watch_no_run("drain_no_run", 5);
        chk("drain_not_idle", 32'(bus.idle), 0);
        bus.busy = 1'b0;
        serve(mk(4'h6, 4'h4, 0, 2, 0, 1'b0, 2'b00, 2), 2);

        // Response backpressure, then reset mid-run with jobs still queued.
        bus.busy = 1'b1;
        push(4'h3, 4'h7);
        push(4'h9, 4'h8);
        push(4'hB, 4'hB);
        bus.busy = 1'b0;
        serve(mk(4'h3, 4'h7, 0, 4, 5, 1'b0, 2'b00, 4), 1);
        wait_run(4'h9, 1);
        @(negedge clk);
        bus.busy = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        bus.busy = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        begin
            bit ran = 1'b0;
            bit rsp = 1'b0;
            repeat (12) begin
                @(negedge clk);
                if (bus.run === 1'b1) ran = 1'b1;
                if (bus.rsp_valid === 1'b1) rsp = 1'b1;
            end
            chk("post_rst_no_run", 32'(ran), 0);
            chk("post_rst_no_rsp", 32'(rsp), 0);
        end
        chk("post_rst_idle", 32'(bus.idle), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_job_launcher.md
Name: seq_job_launcher

Overview:
- Host-side initiator for the microcode sequencer's run/n_func/busy handshake.
- Queues function requests (pairing, Miller loop, final exponentiation), launches them one at a time, and monitors busy rise/fall with timeouts.
- Returns one tagged response per job, carrying status and busy-cycle count.
- Sits between the host command interface and the sequencer; it is the only driver of run and n_func.

Parameters:
- FIFO_DEPTH, 4, command queue entries; power of 2, at least 2.
- START_TO, 8, max cycles after the run pulse for busy to rise.
- CNT_W, 20, width of the busy-cycle counter (also sets the run timeout at 2^CNT_W-1).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  queue not full.
- cmd_func  in  4  function number for n_func.
- cmd_tag  in  4  host tag, echoed in the response.
- run  out  1  one-cycle start pulse to the sequencer.
- n_func  out  4  function number presented to the sequencer.
- busy  in  1  sequencer busy (same clock domain, no synchroniser).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts response.
- rsp_tag  out  4  tag of the completed job.
- rsp_status  out  2  00 ok, 01 start timeout, 10 run timeout.
- rsp_cycles  out  CNT_W  cycles busy was high for this job.
- idle  out  1  state IDLE and queue empty.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, queue empty, run=0, n_func=0, rsp_valid=0, rsp_tag=0, rsp_status=0, rsp_cycles=0, cmd_ready=1, idle=1.
- Queue: push on cmd_valid&&cmd_ready; cmd_ready=(count!=FIFO_DEPTH), registered from count. A push while full is ignored. Pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop keeps count unchanged.
- IDLE: if queue non-empty, pop the head, latch func/tag, load n_func, go to LAUNCH. Push at cycle t into an empty queue in IDLE -> pop at t+1 -> run high at t+2.
- LAUNCH (1 cycle): run=1, clear counters, go to WAIT_START.
- run is high only in LAUNCH, exactly one cycle per job.
- n_func is stable from LAUNCH until the response is accepted.
- WAIT_START: count cycles.
  - busy=1 -> RUNNING; this cycle counts as busy cycle 1.
  - Counter reaches START_TO with busy=0 -> status=01, cycles=0 -> RESPOND.
- RUNNING: increment rsp_cycles each cycle busy=1.
  - busy=0 -> status=00 -> RESPOND.
  - Counter reaches 2^CNT_W-1 with busy still 1 -> status=10, saturate -> DRAIN.
- DRAIN: rsp_valid=1 as in RESPOND, but after the handshake stay in DRAIN until busy=0, then IDLE. No launch while busy=1.
- RESPOND: rsp_valid=1; tag/status/cycles held stable until rsp_valid&&rsp_ready; then IDLE. The next pop occurs at the earliest one cycle after the handshake.
- busy=1 observed in IDLE (external glitch or stale run): no launch until busy=0.
- rsp_ready high before rsp_valid has no effect.
- cmd_func values are passed through unchecked.
- Reset mid-job: queue flushed, run=0 immediately, in-flight job lost with no response.

Test Plan:
- Single job: push func=1 tag=3 at t0; busy high t0+3..t0+12 -> run only at t0+2, n_func=1; rsp tag=3, status=00, cycles=10.
- Back-to-back: push func 0,2,1 with tags 5,6,7 in consecutive cycles -> three run pulses, each after the prior busy fall plus handshake; responses in order, tags 5,6,7.
- Queue full: FIFO_DEPTH=4, sequencer held busy=1 -> cmd_ready drops after 5 accepted pushes (1 launched + 4 queued); a 6th push with cmd_valid=1 is not accepted; one completion -> cmd_ready=1.
- Start timeout: busy never rises -> after START_TO=8 cycles rsp status=01, cycles=0; the next queued job still launches.
- Run timeout: CNT_W=4, busy stuck high -> status=10, cycles=15; no new run until busy falls, then the next job launches.
- Backpressure and reset: rsp_ready=0 for 5 cycles -> rsp fields stable, no new run; assert rstn=0 mid-RUNNING -> all outputs at reset values, idle=1 after release.
